fifo_param: RTL
===============

// Module: fifo_param
// PURPOSE
//  Parametrised synchronous FIFO; next generation of the 8x16 UART/sensor FIFO.
//  Adds configurable width/depth, occupancy count, almost-full/almost-empty
//  thresholds, sticky overflow/underflow error flags and a synchronous flush.
//  Sits between the UART RX/TX engines and the command/sensor logic.
// PARAMETERS
//  DATA_W   8    data word width in bits
//  ADDR_W   4    address width; DEPTH = 2**ADDR_W entries (ADDR_W >= 2)
//  AF_LVL   12   almost_full asserted when count >= AF_LVL (1..DEPTH)
//  AE_LVL   2    almost_empty asserted when count <= AE_LVL (0..DEPTH-1)
// PORTS
//  clk           in   1         system clock, rising edge
//  reset         in   1         asynchronous, active-high reset
//  flush         in   1         synchronous clear of pointers/count (data kept)
//  wdata         in   DATA_W    write data
//  wr            in   1         write request
//  full          out  1         count == DEPTH
//  almost_full   out  1         count >= AF_LVL
//  rdata         out  DATA_W    head-of-queue word (show-ahead)
//  rd            in   1         read/pop request
//  empty         out  1         count == 0
//  almost_empty  out  1         count <= AE_LVL
//  count         out  ADDR_W+1  current occupancy 0..DEPTH
//  overflow      out  1         sticky: write attempted while full and not accepted
//  underflow     out  1         sticky: read attempted while empty
//  clr_err       in   1         synchronous clear of overflow/underflow
// BEHAVIOUR
//  - Reset: wptr=rptr=0, count=0, empty=1, almost_empty=1, full=0,
//    almost_full=0, overflow=underflow=0, all mem words 0, so rdata=0.
//  - All flags registered; full/empty derive from registered count
//    (count==DEPTH / count==0), no extra pointer MSB needed.
//  - rdata = mem[rptr] combinationally; valid when empty=0, zero read latency.
//    rd pops on clk edge; next word visible the following cycle.
//  - Write accepted iff wr && !full: mem[wptr]<=wdata, wptr+1 (mod DEPTH).
//  - Read accepted iff rd && !empty: rptr+1 (mod DEPTH).
//  - Pointers wrap naturally at DEPTH-1 -> 0.
//  - count next = count + wacc - racc (ADDR_W+1 bits, never exceeds DEPTH).
//  - wr&&rd, not full, not empty: both accepted, count unchanged.
//  - wr&&rd while empty: write only; count 0->1; underflow set.
//  - wr&&rd while full: read only; write dropped; count DEPTH->DEPTH-1;
//    overflow set.
//  - wr while full (no rd): dropped, overflow set; memory untouched.
//  - rd while empty (no wr): ignored, underflow set; rptr unchanged.
//  - flush (priority over wr/rd same cycle): wptr=rptr=count=0, empty=1,
//    full=0; mem not cleared; error flags unaffected; wr/rd that cycle ignored
//    and do not set error flags.
//  - clr_err: clears overflow/underflow; a new error event in the same cycle
//    wins (flag stays 1).
//  - reset asserted mid-operation: immediate return to reset state, all
//    queued data discarded.
// TESTING
//  1 reset -> empty=1, count=0, rdata=0, full=0, overflow=underflow=0.
//  2 write 0x01..0x10 (16 cycles, defaults) -> full=1, count=16,
//    almost_full from 12th write; read 16 -> 0x01..0x10 in order, empty=1.
//  3 fill 16, then wr=1 wdata=0xAA, rd=0 -> dropped, overflow=1, count=16;
//    clr_err -> overflow=0.
//  4 empty, wr&rd with 0x55 -> count=1, rdata=0x55, underflow=1.
//  5 count=5, wr&rd for 20 cycles -> count stays 5, pointers wrap, data order kept.
//  6 count=7, flush with wr=1 -> count=0, empty=1, no write, no error;
//    reset mid-burst -> reset state.

Source files
------------

// File: rtl/fifo_param_if.sv
// Handshake/status bundle between a FIFO producer/consumer (master) and the FIFO (slave).
interface fifo_param_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
);
  logic              flush;
  logic [DATA_W-1:0] wdata;
  logic              wr;
  logic              full;
  logic              almost_full;
  logic [DATA_W-1:0] rdata;
  logic              rd;
  logic              empty;
  logic              almost_empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;
  logic              clr_err;

  modport master (
    output flush, wdata, wr, rd, clr_err,
    input  full, almost_full, rdata, empty, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  flush, wdata, wr, rd, clr_err,
    output full, almost_full, rdata, empty, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_param.sv
// Parametrised show-ahead synchronous FIFO with occupancy count, threshold flags,
// sticky overflow/underflow errors and a synchronous flush.
module fifo_param #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned AF_LVL = 12,
  parameter int unsigned AE_LVL = 2
) (
  input logic       clk,
  input logic       reset,
  fifo_param_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DepthCnt = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] AfCnt    = (ADDR_W + 1)'(AF_LVL);
  localparam logic [ADDR_W:0] AeCnt    = (ADDR_W + 1)'(AE_LVL);

  if (ADDR_W < 2) begin : g_bad_addr_w
    $error("fifo_param: ADDR_W must be >= 2");
  end
  if (AF_LVL < 1 || AF_LVL > DEPTH) begin : g_bad_af_lvl
    $error("fifo_param: AF_LVL out of range");
  end
  if (AE_LVL > DEPTH - 1) begin : g_bad_ae_lvl
    $error("fifo_param: AE_LVL out of range");
  end

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              afull_q, afull_d;
  logic              aempty_q, aempty_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              wacc, racc;
  logic              set_ovf, set_unf;

  // Flush masks all requests, including their error side effects.
  always_comb begin
    wacc    = 1'b0;
    racc    = 1'b0;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    if (!bus.flush) begin
      wacc    = bus.wr && !full_q;
      racc    = bus.rd && !empty_q;
      set_ovf = bus.wr && full_q;
      set_unf = bus.rd && empty_q;
    end
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (bus.flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      wptr_d  = wptr_q + ADDR_W'(wacc);
      rptr_d  = rptr_q + ADDR_W'(racc);
      count_d = count_q + (ADDR_W + 1)'(wacc) - (ADDR_W + 1)'(racc);
    end
    full_d   = (count_d == DepthCnt);
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= AfCnt);
    aempty_d = (count_d <= AeCnt);
    // A new error event in the clearing cycle keeps the flag set.
    ovf_d    = set_ovf || (ovf_q && !bus.clr_err);
    unf_d    = set_unf || (unf_q && !bus.clr_err);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wacc) begin
      mem_q[wptr_q] <= bus.wdata;
    end
  end

  assign bus.rdata        = mem_q[rptr_q];
  assign bus.count        = count_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = afull_q;
  assign bus.almost_empty = aempty_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;

endmodule
